// File: rtl/mac_array_engine_if.sv
// Operand/result stream bundle for mac_array_engine.
// master = host/consumer side, slave = engine side.
interface mac_array_engine_if #(
  parameter int DW    = 8,
  parameter int ACC_W = 18
);
  logic             start;
  logic             cfg_signed;
  logic             in_val;
  logic             in_rdy;
  logic [DW-1:0]    in_data;
  logic             out_val;
  logic             out_rdy;
  logic [ACC_W-1:0] out_data;
  logic             out_last;
  logic             busy;
  logic             done;
  logic             sat_flag;

  modport master (
    output start, cfg_signed, in_val, in_data, out_rdy,
    input  in_rdy, out_val, out_data, out_last, busy, done, sat_flag
  );
  modport slave (
    input  start, cfg_signed, in_val, in_data, out_rdy,
    output in_rdy, out_val, out_data, out_last, busy, done, sat_flag
  );
endinterface

// File: rtl/mac_array_engine.sv
// C[MxN] = A[MxK] * B[KxN] with LANES parallel MAC lanes, streamed over valid/ready.
// Define MAC_SATURATE_EN for clamping accumulation with sticky sat_flag; default wraps.
module mac_lane #(
  parameter int DW    = 8,
  parameter int ACC_W = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sgn,
  input  logic             clr,
  input  logic             en,
  input  logic [DW-1:0]    a,
  input  logic [DW-1:0]    b,
  output logic [ACC_W-1:0] acc,
  output logic             sat
);
  logic [2*DW-1:0]  ax, bx, prod_d, prod_q;
  logic [ACC_W-1:0] pext, base, acc_d, acc_q;
`ifdef MAC_SATURATE_EN
  logic [ACC_W:0]   sum;
  logic             ovf;
`endif

  always_comb begin
    ax     = sgn ? {{DW{a[DW-1]}}, a} : {{DW{1'b0}}, a};
    bx     = sgn ? {{DW{b[DW-1]}}, b} : {{DW{1'b0}}, b};
    prod_d = ax * bx;
    pext   = ACC_W'(prod_q);
    if (sgn && prod_q[2*DW-1]) pext = pext | ~ACC_W'({(2*DW){1'b1}});
    base   = clr ? '0 : acc_q;
`ifdef MAC_SATURATE_EN
    // one guard bit decides overflow for both signed and unsigned views
    sum = {sgn & base[ACC_W-1], base} + {sgn & pext[ACC_W-1], pext};
    ovf = sgn ? (sum[ACC_W] ^ sum[ACC_W-1]) : sum[ACC_W];
    if (!ovf)      acc_d = sum[ACC_W-1:0];
    else if (!sgn) acc_d = '1;
    else           acc_d = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    sat = en & ovf;
`else
    acc_d = base + pext;
    sat   = 1'b0;
`endif
    if (!en) acc_d = acc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
      acc_q  <= '0;
    end else begin
      prod_q <= prod_d;
      acc_q  <= acc_d;
    end
  end

  assign acc = acc_q;
endmodule

module mac_array_engine #(
  parameter int param_M = 4,
  parameter int param_K = 4,
  parameter int param_N = 4,
  parameter int DW      = 8,
  parameter int ACC_W   = 2*DW + $clog2(param_K),
  parameter int LANES   = 1
) (
  input  logic clk,
  input  logic rst,
  mac_array_engine_if.slave bus
);
  localparam int MK = param_M*param_K;
  localparam int KN = param_K*param_N;
  localparam int MN = param_M*param_N;
  localparam int G  = param_N/LANES;
  localparam int CW = 16;
  localparam int STAGES = 1;

  generate
    if ((param_N % LANES) != 0) begin : g_bad_lanes
      $error("LANES must divide param_N");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;
  state_t state_q, state_d;

  logic [DW-1:0]    a_q [MK], a_d [MK];
  logic [DW-1:0]    b_q [KN], b_d [KN];
  logic [ACC_W-1:0] c_q [MN], c_d [MN];

  logic          sgn_q, sgn_d, issue_q, issue_d, first_q, first_d;
  logic [CW-1:0] in_cnt_q, in_cnt_d, i_q, i_d, g_q, g_d, k_q, k_d, idx_q, idx_d;
  logic [STAGES:0]         vld_pipe_q, vld_pipe_d, last_pipe_q, last_pipe_d;
  logic [STAGES:0][CW-1:0] cidx_pipe_q, cidx_pipe_d;
  logic             in_rdy_q, in_rdy_d, out_val_q, out_val_d, out_last_q, out_last_d;
  logic             busy_q, busy_d, done_q, done_d, sat_q, sat_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;

  logic [DW-1:0]                   lane_a;
  logic [LANES-1:0][DW-1:0]        lane_b;
  logic [LANES-1:0][ACC_W-1:0]     lane_acc;
  logic [LANES-1:0]                lane_sat;

  always_comb begin
    lane_a = a_q[int'(i_q)*param_K + int'(k_q)];
    for (int l = 0; l < LANES; l++)
      lane_b[l] = b_q[int'(k_q)*param_N + int'(g_q)*LANES + l];
  end

  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      mac_lane #(.DW(DW), .ACC_W(ACC_W)) u_lane (
        .clk(clk), .rst(rst), .sgn(sgn_q), .clr(first_q), .en(vld_pipe_q[0]),
        .a(lane_a), .b(lane_b[l]), .acc(lane_acc[l]), .sat(lane_sat[l])
      );
    end
  endgenerate

  always_comb begin
    state_d = state_q;  sgn_d = sgn_q;  issue_d = issue_q;  first_d = first_q;
    in_cnt_d = in_cnt_q;  i_d = i_q;  g_d = g_q;  k_d = k_q;  idx_d = idx_q;
    in_rdy_d = in_rdy_q;  out_val_d = out_val_q;  out_last_d = out_last_q;
    out_data_d = out_data_q;  busy_d = busy_q;  done_d = 1'b0;
    sat_d = sat_q | (|lane_sat);
    a_d = a_q;  b_d = b_q;  c_d = c_q;
    vld_pipe_d  = {vld_pipe_q[STAGES-1:0], 1'b0};
    last_pipe_d = {last_pipe_q[STAGES-1:0], 1'b0};
    cidx_pipe_d = {cidx_pipe_q[STAGES-1:0], CW'(0)};

    // issue stage: walk (i, group, k) with k innermost
    if (issue_q) begin
      vld_pipe_d[0]  = 1'b1;
      first_d        = (k_q == '0);
      last_pipe_d[0] = (k_q == CW'(param_K-1));
      cidx_pipe_d[0] = CW'(int'(i_q)*param_N + int'(g_q)*LANES);
      k_d = k_q + 1'b1;
      if (k_q == CW'(param_K-1)) begin
        k_d = '0;
        g_d = g_q + 1'b1;
        if (g_q == CW'(G-1)) begin
          g_d = '0;
          i_d = i_q + 1'b1;
          if (i_q == CW'(param_M-1)) begin
            i_d = '0;
            issue_d = 1'b0;
          end
        end
      end
    end

    if (vld_pipe_q[STAGES] && last_pipe_q[STAGES])
      for (int l = 0; l < LANES; l++) c_d[int'(cidx_pipe_q[STAGES]) + l] = lane_acc[l];

    case (state_q)
      IDLE: if (bus.start) begin
        state_d = LOAD;  sgn_d = bus.cfg_signed;  sat_d = 1'b0;
        in_cnt_d = '0;  in_rdy_d = 1'b1;  busy_d = 1'b1;
      end
      LOAD: if (bus.in_val && in_rdy_q) begin
        if (int'(in_cnt_q) < MK) a_d[int'(in_cnt_q)] = bus.in_data;
        else                     b_d[int'(in_cnt_q) - MK] = bus.in_data;
        in_cnt_d = in_cnt_q + 1'b1;
        if (in_cnt_q == CW'(MK+KN-1)) begin
          state_d = COMPUTE;  in_rdy_d = 1'b0;  issue_d = 1'b1;
          i_d = '0;  g_d = '0;  k_d = '0;
        end
      end
      COMPUTE: if (vld_pipe_q[STAGES] && last_pipe_q[STAGES] &&
                   cidx_pipe_q[STAGES] == CW'(MN-LANES)) begin
        // c_d forwards the element written on this same edge when MN == LANES
        state_d = DRAIN;  out_val_d = 1'b1;  idx_d = '0;
        out_data_d = c_d[0];  out_last_d = (MN == 1);
      end
      DRAIN: if (bus.out_rdy) begin
        if (idx_q == CW'(MN-1)) begin
          state_d = IDLE;  out_val_d = 1'b0;  out_last_d = 1'b0;
          out_data_d = '0;  busy_d = 1'b0;  done_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
          out_data_d = c_q[int'(idx_q) + 1];
          out_last_d = (idx_q == CW'(MN-2));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;  sgn_q <= 1'b0;  issue_q <= 1'b0;  first_q <= 1'b0;
      in_cnt_q <= '0;  i_q <= '0;  g_q <= '0;  k_q <= '0;  idx_q <= '0;
      vld_pipe_q <= '0;  last_pipe_q <= '0;  cidx_pipe_q <= '0;
      in_rdy_q <= 1'b0;  out_val_q <= 1'b0;  out_last_q <= 1'b0;  out_data_q <= '0;
      busy_q <= 1'b0;  done_q <= 1'b0;  sat_q <= 1'b0;
    end else begin
      state_q <= state_d;  sgn_q <= sgn_d;  issue_q <= issue_d;  first_q <= first_d;
      in_cnt_q <= in_cnt_d;  i_q <= i_d;  g_q <= g_d;  k_q <= k_d;  idx_q <= idx_d;
      vld_pipe_q <= vld_pipe_d;  last_pipe_q <= last_pipe_d;  cidx_pipe_q <= cidx_pipe_d;
      in_rdy_q <= in_rdy_d;  out_val_q <= out_val_d;  out_last_q <= out_last_d;
      out_data_q <= out_data_d;  busy_q <= busy_d;  done_q <= done_d;  sat_q <= sat_d;
    end
  end

  // operand/result buffers hold don't-care contents across reset
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
    c_q <= c_d;
  end

  assign bus.in_rdy   = in_rdy_q;
  assign bus.out_val  = out_val_q;
  assign bus.out_data = out_data_q;
  assign bus.out_last = out_last_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sat_flag = sat_q;
endmodule

// File: tb/tb_mac_array_engine.sv
// Scoreboard bench: three engines (LANES=1, LANES=2, ACC_W=16) fed the same stream,
// expected C from an arithmetic reference model, checked by a decoupled monitor.
module tb_mac_array_engine;
`ifdef MAC_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       h_rst = 1'b1, h_start = 1'b0, h_cfg = 1'b0, h_in_val = 1'b0, h_out_rdy = 1'b1;
  logic [7:0] h_in_data = '0;
  bit         rdy_toggle = 1'b0;

  mac_array_engine_if #(.DW(8), .ACC_W(18)) if0 ();
  mac_array_engine_if #(.DW(8), .ACC_W(18)) if1 ();
  mac_array_engine_if #(.DW(8), .ACC_W(16)) if2 ();

  mac_array_engine #(.LANES(1))              u0 (.clk(clk), .rst(h_rst), .bus(if0));
  mac_array_engine #(.LANES(2))              u1 (.clk(clk), .rst(h_rst), .bus(if1));
  mac_array_engine #(.LANES(1), .ACC_W(16))  u2 (.clk(clk), .rst(h_rst), .bus(if2));

  assign if0.start = h_start;  assign if0.cfg_signed = h_cfg;  assign if0.in_val = h_in_val;
  assign if0.in_data = h_in_data;  assign if0.out_rdy = h_out_rdy;
  assign if1.start = h_start;  assign if1.cfg_signed = h_cfg;  assign if1.in_val = h_in_val;
  assign if1.in_data = h_in_data;  assign if1.out_rdy = h_out_rdy;
  assign if2.start = h_start;  assign if2.cfg_signed = h_cfg;  assign if2.in_val = h_in_val;
  assign if2.in_data = h_in_data;  assign if2.out_rdy = h_out_rdy;

  logic        ov [3], ol [3], ir [3], bz [3], dn [3], sf [3];
  logic [17:0] od [3];
  assign ov[0] = if0.out_val;  assign ol[0] = if0.out_last;  assign ir[0] = if0.in_rdy;
  assign bz[0] = if0.busy;     assign dn[0] = if0.done;      assign sf[0] = if0.sat_flag;
  assign od[0] = if0.out_data;
  assign ov[1] = if1.out_val;  assign ol[1] = if1.out_last;  assign ir[1] = if1.in_rdy;
  assign bz[1] = if1.busy;     assign dn[1] = if1.done;      assign sf[1] = if1.sat_flag;
  assign od[1] = if1.out_data;
  assign ov[2] = if2.out_val;  assign ol[2] = if2.out_last;  assign ir[2] = if2.in_rdy;
  assign bz[2] = if2.busy;     assign dn[2] = if2.done;      assign sf[2] = if2.sat_flag;
  assign od[2] = {2'b00, if2.out_data};

  int total = 0, bad = 0;
  logic [17:0] q0 [$], q1 [$], q2 [$];
  bit   exp_sat [3];
  int   exp_cc  [3] = '{66, 34, 66};
  int   bc [3], cc [3], jobs [3];
  bit   stall [3], pend [3];
  logic [17:0] hd [3];
  logic        hl [3];
  logic [7:0]  A_m [16], B_m [16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: C[i][j] = sum_k A[i][k]*B[k][j], clamped per step or wrapped to w bits
  task automatic model(input bit sgn, input int w, input int u);
    longint lo, hi, acc, av, bv;
    bit s;
    s  = 0;
    lo = sgn ? -(longint'(1) <<< (w-1)) : 0;
    hi = sgn ? (longint'(1) <<< (w-1)) - 1 : (longint'(1) <<< w) - 1;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        acc = 0;
        for (int k = 0; k < 4; k++) begin
          av  = sgn ? longint'($signed(A_m[i*4+k])) : longint'(A_m[i*4+k]);
          bv  = sgn ? longint'($signed(B_m[k*4+j])) : longint'(B_m[k*4+j]);
          acc = acc + av*bv;
          if (SAT_EN && acc > hi) begin acc = hi; s = 1; end
          if (SAT_EN && acc < lo) begin acc = lo; s = 1; end
        end
        acc = acc & ((longint'(1) <<< w) - 1);
        case (u)
          0: q0.push_back(18'(acc));
          1: q1.push_back(18'(acc));
          default: q2.push_back(18'(acc));
        endcase
      end
    exp_sat[u] = s;
  endtask

  initial forever begin
    @(posedge clk); #1;
    h_out_rdy = rdy_toggle ? ~h_out_rdy : 1'b1;
  end

  always @(negedge clk) begin
    for (int u = 0; u < 3; u++) begin
      if (h_rst) begin
        bc[u] = 0; cc[u] = 0; stall[u] = 0; pend[u] = 0;
      end else begin
        if (pend[u]) begin
          chk($sformatf("u%0d done", u), dn[u], 1);
          chk($sformatf("u%0d busy_after_done", u), bz[u], 0);
          chk($sformatf("u%0d sat_flag", u), sf[u], exp_sat[u]);
          chk($sformatf("u%0d compute_cycles", u), cc[u], exp_cc[u]);
          pend[u] = 0; cc[u] = 0; jobs[u]++;
        end
        if (bz[u] && !ir[u] && !ov[u]) cc[u]++;
        if (stall[u]) begin
          chk($sformatf("u%0d stall_val", u), ov[u], 1);
          chk($sformatf("u%0d stall_data", u), od[u], hd[u]);
          chk($sformatf("u%0d stall_last", u), ol[u], hl[u]);
        end
        stall[u] = 0;
        if (ov[u]) begin
          if (h_out_rdy) begin
            logic [17:0] e;
            int sz;
            sz = (u == 0) ? q0.size() : (u == 1) ? q1.size() : q2.size();
            if (sz == 0) begin
              total++; bad++;
              $display("FAIL u%0d unexpected_beat: got %0h expected none", u, od[u]);
            end else begin
              case (u)
                0: e = q0.pop_front();
                1: e = q1.pop_front();
                default: e = q2.pop_front();
              endcase
              chk($sformatf("u%0d data[%0d]", u, bc[u]), od[u], e);
            end
            chk($sformatf("u%0d last[%0d]", u, bc[u]), ol[u], bc[u] == 15);
            bc[u]++;
            if (bc[u] == 16) begin pend[u] = 1; bc[u] = 0; end
          end else begin
            stall[u] = 1; hd[u] = od[u]; hl[u] = ol[u];
          end
        end
      end
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic start_job(input bit sgn);
    int n = 0;
    while (bz[0] || bz[1] || bz[2]) begin
      tick(); n++;
      if (n > 2000) begin total++; bad++; $display("FAIL idle_wait: got busy expected idle"); return; end
    end
    h_cfg = sgn; h_start = 1'b1;
    tick();
    h_start = 1'b0;
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("u%0d sat_clr_on_start", u), sf[u], 0);
      chk($sformatf("u%0d in_rdy_load", u), ir[u], 1);
    end
  endtask

  task automatic load_all(input bit gaps);
    for (int b = 0; b < 32; b++) begin
      bit acc;
      int n = 0;
      h_in_data = (b < 16) ? A_m[b] : B_m[b-16];
      do begin
        h_in_val = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        acc = h_in_val && ir[0];
        tick(); n++;
        if (n > 200) begin total++; bad++; $display("FAIL load_wait: got no accept expected accept"); h_in_val = 1'b0; return; end
      end while (!acc);
    end
    h_in_val = 1'b0;
  endtask

  task automatic run_job(input bit sgn, input bit gaps, input bit toggle);
    int j0 [3];
    int n = 0;
    rdy_toggle = toggle;
    model(sgn, 18, 0); model(sgn, 18, 1); model(sgn, 16, 2);
    for (int u = 0; u < 3; u++) j0[u] = jobs[u];
    start_job(sgn);
    load_all(gaps);
    while (jobs[0] == j0[0] || jobs[1] == j0[1] || jobs[2] == j0[2]) begin
      tick(); n++;
      if (n > 3000) begin total++; bad++; $display("FAIL job_wait: got incomplete expected done"); break; end
    end
    rdy_toggle = 1'b0;
  endtask

  task automatic rand_ops();
    for (int n = 0; n < 16; n++) begin
      A_m[n] = 8'($urandom);
      B_m[n] = 8'($urandom);
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int u = 0; u < 3; u++)
      chk($sformatf("u%0d %s outs", u, tag), {ir[u], ov[u], ol[u], bz[u], dn[u], sf[u], od[u]}, 0);
  endtask

  initial begin
    repeat (3) tick();
    @(negedge clk);
    chk_zero("reset");
    tick(); h_rst = 1'b0;

    for (int n = 0; n < 16; n++) begin A_m[n] = (n/4 == n%4) ? 8'd1 : 8'd0; B_m[n] = 8'(n+1); end
    run_job(1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 16; n++) begin A_m[n] = 8'hFF; B_m[n] = 8'h02; end
    run_job(1'b1, 1'b0, 1'b0);
    rand_ops(); run_job(1'b0, 1'b1, 1'b1);
    rand_ops(); run_job(1'b1, 1'b1, 1'b1);
    for (int n = 0; n < 16; n++) begin A_m[n] = 8'hFF; B_m[n] = 8'hFF; end
    run_job(1'b0, 1'b0, 1'b0);
    rand_ops(); run_job(1'b0, 1'b0, 1'b1);

    // abort mid-COMPUTE; a start during the job must not disturb it
    rand_ops();
    start_job(1'b0);
    load_all(1'b0);
    repeat (10) tick();
    h_start = 1'b1; tick(); h_start = 1'b0;
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("u%0d busy_ignored_start", u), bz[u], 1);
      chk($sformatf("u%0d in_rdy_ignored_start", u), ir[u], 0);
      chk($sformatf("u%0d out_val_ignored_start", u), ov[u], 0);
    end
    h_rst = 1'b1;
    q0.delete(); q1.delete(); q2.delete();
    @(negedge clk);
    @(negedge clk);
    chk_zero("midjob_reset");
    tick(); h_rst = 1'b0;
    rand_ops(); run_job(1'b1, 1'b1, 1'b1);

    repeat (5) tick();
    chk("q0 leftover", q0.size(), 0);
    chk("q1 leftover", q1.size(), 0);
    chk("q2 leftover", q2.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
